control_unit: RTL
=================

# control_unit

Multi-cycle instruction sequencer for the 8-bit accumulator CPU. It fetches a 16-bit instruction from the asynchronous instruction ROM and holds it in an instruction register. It then drives the operand-select lines of the two ALU input muxes, the ALU operation, and the A/B register load enables. Its `sel_a` output is the `s` input of the A-side operand mux (00 reg A, 01 const 1, 10 const 0, 11 reg B). It also owns the program counter and the latched Z/N/C status flags used by conditional jumps.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `instr`  in  16  ROM data at address `pc`: [15:8] opcode, [7:0] literal.
- `alu_z`, `alu_n`, `alu_c`  in  1 each  combinational ALU flags for the current operation.
- `pc`  out  8  instruction address (registered).
- `lit`  out  8  literal field of the IR, routed to the B-side mux.
- `sel_a`  out  2  A-side mux select: 00 A, 01 const 1, 10 const 0, 11 B.
- `sel_b`  out  2  B-side mux select: 00 B, 01 lit, 10 const 0, 11 A.
- `alu_op`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR; other codes unused.
- `load_a`, `load_b`  out  1 each  register write enables.
- `halted`  out  1  high while in the HALT state.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- FSM states: FETCH, EXEC, HALT.
- FETCH: IR <= `instr`, then go to EXEC. Controls are idle: sel 00/00, `alu_op` 000, loads 0.
- EXEC: decode the IR combinationally onto the control outputs. At the closing edge, update `pc` and the flags, then return to FETCH.
- Opcodes, listed as opcode: sel_a / sel_b / alu_op / load / flag update.
  - 0x00 NOP: idle.
  - 0x01 MOV A,B: 10/00/ADD/load_a.
  - 0x02 MOV B,A: 00/10/ADD/load_b.
  - 0x03 MOV A,lit: 10/01/ADD/load_a.
  - 0x04 MOV B,lit: 10/01/ADD/load_b.
  - 0x05 ADD A,B: 00/00/ADD/load_a/flags.
  - 0x06 SUB A,B: 00/00/SUB/load_a/flags.
  - 0x07 INC B: 01/00/ADD/load_b/flags.
  - 0x08 AND A,B: 00/00/AND/load_a/flags.
  - 0x09 OR A,B: 00/00/OR/load_a/flags.
  - 0x0A CMP A,B: 00/00/SUB/no load/flags.
  - 0x0B JMP lit, 0x0C JEQ lit (taken when Z=1), 0x0D JNE lit (taken when Z=0): idle controls.
  - 0x0E HALT.
  - Any other opcode: behaves as NOP and raises `illegal` for the EXEC cycle.
- PC update: `pc` <= `lit` when a jump is taken, otherwise `pc`+1. The increment is mod 256 (0xFF wraps to 0x00).
- Flags: when the opcode updates flags, Z/N/C <= `alu_z`/`alu_n`/`alu_c` at the end of EXEC. Otherwise the flags hold.
- Jumps test the flag value latched before the current instruction.
- HALT opcode: at the end of EXEC, go to HALT with `pc` unchanged. In HALT, `halted`=1, controls are idle, and the FSM stays there until `rst`.
- Mux select values outside FETCH/EXEC are don't-care to the datapath but must still be driven to the idle values.

## Timing
- Every non-halting instruction takes exactly 2 cycles: FETCH then EXEC.
- Loads and `illegal` assert only during EXEC, for exactly one cycle. `load_a` and `load_b` are never high together.
- The datapath register captures the ALU result on the same edge that ends EXEC.
- `pc` changes only on the edge ending EXEC. `instr` is sampled only on the edge ending FETCH.
- Reset values: state FETCH, `pc` 0x00, IR 0x0000, flags 0, `halted` 0, `illegal` 0, `lit` 0x00, sel 00/00, `alu_op` 000, loads 0.
- `load_a`, `load_b` and `illegal` are gated by !`rst`. A reset asserted mid-EXEC therefore produces no register write and no flag update.
- Reset takes priority over HALT and over any EXEC action.
- Back-to-back instructions have no bubble: FETCH follows EXEC immediately.

## Test plan
- Reset, then ROM[0]=0x0305 (MOV A,5) -> cycle 1 FETCH; cycle 2 EXEC with sel_a=10, sel_b=01, lit=0x05, load_a=1; `pc`=0x01 after that edge.
- Program CMP then JEQ 0x20 with `alu_z`=1 during CMP EXEC -> `pc`=0x20 after JEQ EXEC. Repeat with `alu_z`=0 -> `pc`=CMP address+2.
- ROM[0xFF]=0x0000 (NOP), reached via JMP 0xFF -> after its EXEC `pc` wraps to 0x00.
- Opcode 0x7F -> `illegal`=1 for exactly one cycle, no loads asserted, `pc` advances by 1, flags unchanged.
- HALT at 0x04 -> `halted`=1 and `pc` stays 0x04 for 20 cycles with no loads. Then `rst` -> `pc`=0x00, `halted`=0.
- Assert `rst` during ADD EXEC -> `load_a`=0 in that cycle, flags still 0, and the next cycle is FETCH at `pc`=0x00.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator CPU: FETCH/EXEC/HALT FSM,
// instruction register, program counter and latched Z/N/C flags.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  output logic [7:0]  pc,
  output logic [7:0]  lit,
  output logic [1:0]  sel_a,
  output logic [1:0]  sel_b,
  output logic [2:0]  alu_op,
  output logic        load_a,
  output logic        load_b,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam logic [1:0] SA_A = 2'b00, SA_ONE = 2'b01, SA_ZERO = 2'b10;
  localparam logic [1:0] SB_B = 2'b00, SB_LIT = 2'b01, SB_ZERO = 2'b10;

  state_t      state, next_state;
  logic [15:0] ir;
  logic [7:0]  opcode;
  logic        flag_z, flag_n, flag_c;
  logic        update_flags, jump_taken, is_halt;
  logic        load_a_raw, load_b_raw, illegal_raw;

  assign opcode = ir[15:8];
  assign lit    = ir[7:0];
  assign halted = (state == HALT);

  // Reset masks the write strobes so an aborted EXEC leaves the datapath untouched.
  assign load_a  = load_a_raw  & ~rst;
  assign load_b  = load_b_raw  & ~rst;
  assign illegal = illegal_raw & ~rst;

  always_comb begin
    next_state   = state;
    sel_a        = SA_A;
    sel_b        = SB_B;
    alu_op       = OP_ADD;
    load_a_raw   = 1'b0;
    load_b_raw   = 1'b0;
    illegal_raw  = 1'b0;
    update_flags = 1'b0;
    jump_taken   = 1'b0;
    is_halt      = 1'b0;
    case (state)
      FETCH: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        case (opcode)
          8'h00: ;
          8'h01: begin sel_a = SA_ZERO; sel_b = SB_B;   load_a_raw = 1'b1; end
          8'h02: begin sel_a = SA_A;    sel_b = SB_ZERO; load_b_raw = 1'b1; end
          8'h03: begin sel_a = SA_ZERO; sel_b = SB_LIT; load_a_raw = 1'b1; end
          8'h04: begin sel_a = SA_ZERO; sel_b = SB_LIT; load_b_raw = 1'b1; end
          8'h05: begin load_a_raw = 1'b1; update_flags = 1'b1; end
          8'h06: begin alu_op = OP_SUB; load_a_raw = 1'b1; update_flags = 1'b1; end
          8'h07: begin sel_a = SA_ONE; load_b_raw = 1'b1; update_flags = 1'b1; end
          8'h08: begin alu_op = OP_AND; load_a_raw = 1'b1; update_flags = 1'b1; end
          8'h09: begin alu_op = OP_OR;  load_a_raw = 1'b1; update_flags = 1'b1; end
          8'h0A: begin alu_op = OP_SUB; update_flags = 1'b1; end
          8'h0B: jump_taken = 1'b1;
          8'h0C: jump_taken = flag_z;
          8'h0D: jump_taken = ~flag_z;
          8'h0E: begin is_halt = 1'b1; next_state = HALT; end
          default: illegal_raw = 1'b1;
        endcase
      end
      HALT: next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= 8'h00;
      ir     <= 16'h0000;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FETCH)
        ir <= instr;
      if (state == EXEC && !is_halt)
        pc <= jump_taken ? lit : pc + 8'd1;
      if (state == EXEC && update_flags) begin
        flag_z <= alu_z;
        flag_n <= alu_n;
        flag_c <= alu_c;
      end
    end
  end

endmodule
